// File: rtl/vcp_isa_pkg.sv
// Vector coprocessor ISA definitions: opcodes, opcode classes and the classifier
// shared by the issue queue and the instruction decoder.
package vcp_isa_pkg;

    localparam logic [4:0] VLOAD  = 5'b00000;
    localparam logic [4:0] VSTORE = 5'b00001;
    localparam logic [4:0] VADD   = 5'b00010;
    localparam logic [4:0] VSUB   = 5'b00011;
    localparam logic [4:0] VMUL   = 5'b00100;
    localparam logic [4:0] VSMUL  = 5'b00101;
    localparam logic [4:0] VRSUB  = 5'b00110;
    localparam logic [4:0] VFADD  = 5'b00111;
    localparam logic [4:0] VFSUB  = 5'b01000;
    localparam logic [4:0] VAND   = 5'b01001;
    localparam logic [4:0] VOR    = 5'b01010;
    localparam logic [4:0] VXOR   = 5'b01011;
    localparam logic [4:0] VSLL   = 5'b01100;
    localparam logic [4:0] VSRL   = 5'b01101;
    localparam logic [4:0] VSEQ   = 5'b01110;
    localparam logic [4:0] VSLT   = 5'b01111;

    typedef enum logic [2:0] {
        CLS_MEM,
        CLS_ALU,
        CLS_MUL,
        CLS_FADD,
        CLS_ILLEGAL
    } op_class_t;

    typedef enum logic [1:0] {
        StIdle,
        StWaitLat,
        StWaitMem
    } iq_state_t;

    function automatic op_class_t classify(input logic [4:0] opcode);
        op_class_t cls;
        if (opcode[4]) begin
            cls = CLS_ILLEGAL;
        end else begin
            case (opcode)
                VLOAD, VSTORE: cls = CLS_MEM;
                VMUL, VSMUL:   cls = CLS_MUL;
                VFADD, VFSUB:  cls = CLS_FADD;
                default:       cls = CLS_ALU;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/vcp_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push to a full FIFO or a pop from an
// empty FIFO is ignored.
module vcp_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           full,
    output logic                           empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full     = (count_q == CntW'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr_q];
    assign count    = count_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vcp_issue_queue.sv
// Instruction buffer and issue sequencer: spaces issues by functional-unit latency,
// holds after loads/stores until memory completion and drops illegal opcodes.
module vcp_issue_queue
    import vcp_isa_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned ALU_LAT  = 1,
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned FADD_LAT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [31:0]                    host_instr,
    input  logic                           host_valid,
    output logic                           host_ready,
    output logic [31:0]                    instruction,
    output logic                           instruction_valid,
    input  logic                           mem_done,
    output logic                           illegal_instr,
    output logic                           busy,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

    localparam int unsigned MaxLat = (ALU_LAT > MUL_LAT) ?
        ((ALU_LAT > FADD_LAT) ? ALU_LAT : FADD_LAT) :
        ((MUL_LAT > FADD_LAT) ? MUL_LAT : FADD_LAT);
    localparam int unsigned LatW = $clog2(MaxLat + 1);

    iq_state_t        state_q, state_d;
    logic [LatW-1:0]  lat_q, lat_d, head_lat_m1;
    logic [31:0]      head, instr_q, instr_d;
    logic             valid_q, valid_d, illegal_q, illegal_d;
    logic             fifo_full, fifo_empty, pop;
    op_class_t        head_cls;

    vcp_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (host_valid),
        .push_data (host_instr),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign head_cls = classify(head[31:27]);

    always_comb begin
        head_lat_m1 = '0;
        unique case (head_cls)
            CLS_ALU:  head_lat_m1 = LatW'(ALU_LAT - 1);
            CLS_MUL:  head_lat_m1 = LatW'(MUL_LAT - 1);
            CLS_FADD: head_lat_m1 = LatW'(FADD_LAT - 1);
            default:  head_lat_m1 = '0;
        endcase
    end

    // A memory release lets the queued head go out at the same edge; valid_q marks
    // the issue cycle, where mem_done is ignored.
    assign pop = !fifo_empty &&
                 ((state_q == StIdle) || ((state_q == StWaitMem) && mem_done && !valid_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        case (state_q)
            StWaitLat: begin
                lat_d = lat_q - LatW'(1);
                if (lat_q <= LatW'(1)) state_d = StIdle;
            end
            StWaitMem: begin
                if (mem_done && !valid_q) state_d = StIdle;
            end
            default: ;
        endcase
        if (pop) begin
            unique case (head_cls)
                CLS_ILLEGAL: state_d = StIdle;
                CLS_MEM:     state_d = StWaitMem;
                default: begin
                    lat_d   = head_lat_m1;
                    state_d = (head_lat_m1 != '0) ? StWaitLat : StIdle;
                end
            endcase
        end
    end

    always_comb begin
        valid_d   = pop && (head_cls != CLS_ILLEGAL);
        illegal_d = pop && (head_cls == CLS_ILLEGAL);
        instr_d   = valid_d ? head : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q   <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign instruction       = instr_q;
    assign instruction_valid = valid_q;
    assign illegal_instr     = illegal_q;
    assign host_ready        = !fifo_full;
    assign busy              = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_vcp_issue_queue.sv
// Self-checking bench for vcp_issue_queue: directed scenarios plus random traffic,
// all checked against an issue-schedule model built from the opcode timing rules.
module tb_vcp_issue_queue;

    localparam int unsigned DEPTH    = 8;
    localparam int unsigned ALU_LAT  = 1;
    localparam int unsigned MUL_LAT  = 3;
    localparam int unsigned FADD_LAT = 4;
    localparam int unsigned CW       = $clog2(DEPTH + 1);

    localparam logic [4:0] OP_VLOAD = 5'd0;
    localparam logic [4:0] OP_VADD  = 5'd2;
    localparam logic [4:0] OP_VMUL  = 5'd4;
    localparam logic [4:0] OP_VFADD = 5'd7;
    localparam logic [4:0] OP_VAND  = 5'd9;
    localparam logic [4:0] OP_ILL   = 5'd31;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [31:0]   host_instr = '0;
    logic          host_valid = 1'b0;
    logic          host_ready;
    logic [31:0]   instruction;
    logic          instruction_valid;
    logic          mem_done = 1'b0;
    logic          illegal_instr;
    logic          busy;
    logic [CW-1:0] fifo_count;

    always #5 clk = ~clk;

    vcp_issue_queue #(
        .DEPTH    (DEPTH),
        .ALU_LAT  (ALU_LAT),
        .MUL_LAT  (MUL_LAT),
        .FADD_LAT (FADD_LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .host_instr        (host_instr),
        .host_valid        (host_valid),
        .host_ready        (host_ready),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .mem_done          (mem_done),
        .illegal_instr     (illegal_instr),
        .busy              (busy),
        .fifo_count        (fifo_count)
    );

    typedef struct {logic [31:0] w; int pc;} ent_t;
    typedef struct {int c; logic [31:0] w;} obs_t;

    ent_t mq[$];
    obs_t obs[$];
    int   ill_cyc[$];
    int   cyc = 0;
    int   next_ok = 0;
    int   issue_cyc = 0;
    bit   mem_wait = 1'b0;
    int   total = 0;
    int   bad = 0;
    int   peak = 0;
    logic          s_ready, s_busy;
    logic [CW-1:0] s_cnt;

    // Issue spacing per opcode: -1 illegal, 0 memory, otherwise cycles to next issue.
    function automatic int lat_of(input logic [4:0] op);
        int v = int'(op);
        if (v >= 16) return -1;
        if (v <= 1) return 0;
        if (v == 4 || v == 5) return MUL_LAT;
        if (v == 7 || v == 8) return FADD_LAT;
        return ALU_LAT;
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input int p);
        return {op, 27'(p)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: compare the cycle's outputs with the model, then apply inputs.
    task automatic step(input logic v, input logic [31:0] w, input logic md, input logic rst);
        ent_t        e;
        int          l;
        logic        ev, eil, ebusy;
        logic [31:0] ew;
        int          ecnt;
        @(posedge clk);
        #1;
        cyc++;
        ev = 1'b0; eil = 1'b0; ew = '0;
        if (mq.size() > 0 && mq[0].pc + 2 <= cyc && cyc >= next_ok && !mem_wait) begin
            e = mq.pop_front();
            l = lat_of(e.w[31:27]);
            if (l < 0) begin
                eil = 1'b1;
                next_ok = cyc + 1;
            end else begin
                ev = 1'b1;
                ew = e.w;
                if (l == 0) begin
                    mem_wait = 1'b1;
                    issue_cyc = cyc;
                end else begin
                    next_ok = cyc + l;
                end
            end
        end
        ecnt  = mq.size();
        ebusy = (ecnt != 0) || mem_wait || (next_ok > cyc + 1);
        chk("valid", instruction_valid, ev);
        chk("instr", instruction, ew);
        chk("illegal", illegal_instr, eil);
        chk("count", fifo_count, ecnt);
        chk("ready", host_ready, ecnt != DEPTH);
        chk("busy", busy, ebusy);
        s_ready = host_ready;
        s_busy  = busy;
        s_cnt   = fifo_count;
        if (int'(fifo_count) > peak) peak = int'(fifo_count);
        if (instruction_valid) obs.push_back('{cyc, instruction});
        if (illegal_instr) ill_cyc.push_back(cyc);
        if (mem_wait && md && cyc > issue_cyc) begin
            mem_wait = 1'b0;
            next_ok = cyc + 1;
        end
        if (rst) begin
            mq.delete();
            mem_wait = 1'b0;
            next_ok = 0;
        end else if (v && ecnt != DEPTH) begin
            mq.push_back('{w, cyc});
        end
        host_valid = v && !rst;
        host_instr = w;
        mem_done   = md;
        reset      = rst;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    function automatic void clear_log();
        obs.delete();
        ill_cyc.delete();
        peak = 0;
    endfunction

    initial begin
        int          a, p, n_after;
        logic [31:0] w9;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Back-to-back ALU issue from three consecutive pushes.
        clear_log();
        idle(1);
        a = cyc + 1;
        for (int k = 0; k < 3; k++) step(1'b1, mk(OP_VADD, k + 1), 1'b0, 1'b0);
        idle(5);
        chk("t1_n", obs.size(), 3);
        for (int k = 0; k < 3 && k < obs.size(); k++) begin
            chk("t1_cyc", obs[k].c - a, k + 2);
            chk("t1_word", obs[k].w, mk(OP_VADD, k + 1));
        end
        chk("t1_peak", peak <= 2, 1);

        // Multiply latency spacing.
        clear_log();
        step(1'b1, mk(OP_VMUL, 7), 1'b0, 1'b0);
        step(1'b1, mk(OP_VADD, 8), 1'b0, 1'b0);
        idle(7);
        chk("t2_n", obs.size(), 2);
        if (obs.size() == 2) chk("t2_gap", obs[1].c - obs[0].c, MUL_LAT);

        // Memory hold: mem_done in the issue cycle is ignored, later one releases.
        clear_log();
        a = cyc + 1;
        step(1'b1, mk(OP_VLOAD, 3), 1'b0, 1'b0);
        step(1'b1, mk(OP_VADD, 4), 1'b0, 1'b0);
        p = a + 2;
        step(1'b0, '0, 1'b1, 1'b0);
        idle(4);
        step(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        chk("t3_n", obs.size(), 2);
        if (obs.size() == 2) begin
            chk("t3_load", obs[0].c, p);
            chk("t3_add", obs[1].c, p + 6);
        end

        // Fill the FIFO behind a stalled load; the ninth push must be refused.
        clear_log();
        a = cyc + 1;
        w9 = mk(OP_VADD, 'h999);
        step(1'b1, mk(OP_VLOAD, 'h11), 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(1'b1, mk(OP_VADD, 'h400 + k), 1'b0, 1'b0);
        step(1'b1, w9, 1'b0, 1'b0);
        chk("t4_full_ready", s_ready, 1'b0);
        chk("t4_full_cnt", s_cnt, DEPTH);
        step(1'b1, w9, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("t4_hold_ready", s_ready, 1'b0);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("t4_resume_ready", s_ready, 1'b1);
        chk("t4_resume_cnt", s_cnt, DEPTH - 1);
        idle(10);
        chk("t4_n", obs.size(), 9);
        for (int k = 0; k < obs.size(); k++) chk("t4_no_ninth", obs[k].w == w9, 0);
        if (obs.size() == 9) chk("t4_last", obs[8].w, mk(OP_VADD, 'h407));

        // Illegal opcode between two ALU ops.
        clear_log();
        step(1'b1, mk(OP_VAND, 1), 1'b0, 1'b0);
        step(1'b1, mk(OP_ILL, 2), 1'b0, 1'b0);
        step(1'b1, mk(OP_VAND, 3), 1'b0, 1'b0);
        idle(5);
        chk("t5_ill", ill_cyc.size(), 1);
        chk("t5_n", obs.size(), 2);
        if (obs.size() == 2) chk("t5_gap", obs[1].c - obs[0].c, 2);

        // Reset while waiting on FADD latency with four words queued.
        clear_log();
        a = cyc + 1;
        step(1'b1, mk(OP_VFADD, 1), 1'b0, 1'b0);
        step(1'b1, mk(OP_VFADD, 2), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, mk(OP_VADD, 'h50 + k), 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("t6_pre_cnt", s_cnt, 4);
        chk("t6_pre_busy", s_busy, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0);
        chk("t6_post_cnt", s_cnt, 0);
        chk("t6_post_busy", s_busy, 1'b0);
        idle(6);
        n_after = 0;
        for (int k = 0; k < obs.size(); k++) if (obs[k].c > a + 6) n_after++;
        chk("t6_quiet", n_after, 0);
        a = cyc + 1;
        step(1'b1, mk(OP_VADD, 'h77), 1'b0, 1'b0);
        idle(4);
        chk("t6_restart", obs[obs.size()-1].c, a + 2);

        // Random traffic against the schedule model.
        for (int k = 0; k < 1500; k++) begin
            logic [4:0] op;
            logic       v, md, rs;
            op = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(16, 31))
                                              : 5'($urandom_range(0, 15));
            v  = ($urandom_range(0, 1) == 1);
            md = ($urandom_range(0, 5) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(v, mk(op, int'($urandom_range(0, 32'h7ff_ffff))), md, rs);
        end

        // Drain with memory completion held high.
        for (int k = 0; k < 200 && (mq.size() != 0 || s_busy); k++) step(1'b0, '0, 1'b1, 1'b0);
        chk("drain_q", mq.size(), 0);
        chk("drain_busy", s_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
